// File: rtl/des_pkg.sv
// DES constant tables, key-schedule shifts, FSM state type and bit-permutation helpers.
// Table entries use the 1-based MSB-first bit numbering of the DES standard.
package des_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} des_state_e;

   localparam int IP_TBL [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_TBL [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_TBL [48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int P_TBL [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Each box is stored row-major: index = {b1, b6, b2..b5}.
   localparam int SBOX_TBL [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
      return y;
   endfunction

   function automatic logic [47:0] e_perm(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
      return y;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
      return y;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round with its key-schedule step; zero latency.
// No state and no handshake: backpressure is handled entirely by the enclosing core.
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l,
   input  logic [31:0] r,
   input  logic [27:0] c,
   input  logic [27:0] d,
   input  logic [3:0]  round_idx,
   input  logic        mode,
   output logic [31:0] l_nxt,
   output logic [31:0] r_nxt,
   output logic [27:0] c_nxt,
   output logic [27:0] d_nxt
);

   logic [27:0] c_rot;
   logic [27:0] d_rot;
   logic [3:0]  dec_idx;
   logic [47:0] subkey;
   logic [47:0] sbox_in;
   logic [31:0] sbox_out;
   logic [5:0]  six;

   // Decrypt walks the schedule backwards: round j undoes SHIFT[18-j], i.e. table slot 16-idx.
   assign dec_idx = 4'd0 - round_idx;

   always_comb begin
      c_rot = c;
      d_rot = d;
      if (!mode) begin
         c_rot = rotl28(c, SHIFT_TBL[round_idx]);
         d_rot = rotl28(d, SHIFT_TBL[round_idx]);
      end else if (round_idx != 4'd0) begin
         c_rot = rotr28(c, SHIFT_TBL[dec_idx]);
         d_rot = rotr28(d, SHIFT_TBL[dec_idx]);
      end
   end

   assign subkey  = pc2_perm({c_rot, d_rot});
   assign sbox_in = e_perm(r) ^ subkey;

   always_comb begin
      sbox_out = '0;
      six      = '0;
      for (int s = 0; s < 8; s++) begin
         six      = 6'(sbox_in >> (42 - 6 * s));
         sbox_out = {sbox_out[27:0], 4'(SBOX_TBL[s][{six[5], six[0], six[4:1]}])};
      end
   end

   assign l_nxt = r;
   assign r_nxt = l ^ p_perm(sbox_out);
   assign c_nxt = c_rot;
   assign d_nxt = d_rot;

endmodule

// File: rtl/des_iterative_core.sv
// Iterative DES encrypt/decrypt, ROUNDS_PER_CYCLE rounds per clock; result 16/ROUNDS_PER_CYCLE edges after accept.
// Accepts only when idle; holds the result in DONE until out_ready, so no new request is taken meanwhile.
module des_iterative_core
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [63:0] key,
   input  logic [63:0] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] data_out,
   output logic        busy
);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
       ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
      $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   des_state_e  state_q;
   des_state_e  state_d;
   logic [31:0] l_q;
   logic [31:0] r_q;
   logic [27:0] c_q;
   logic [27:0] d_q;
   logic [4:0]  cnt_q;
   logic        mode_q;
   logic        last_round;

   logic [31:0] l_ch [ROUNDS_PER_CYCLE+1];
   logic [31:0] r_ch [ROUNDS_PER_CYCLE+1];
   logic [27:0] c_ch [ROUNDS_PER_CYCLE+1];
   logic [27:0] d_ch [ROUNDS_PER_CYCLE+1];

   assign l_ch[0] = l_q;
   assign r_ch[0] = r_q;
   assign c_ch[0] = c_q;
   assign d_ch[0] = d_q;

   for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
      des_round u_round (
         .l         (l_ch[k]),
         .r         (r_ch[k]),
         .c         (c_ch[k]),
         .d         (d_ch[k]),
         .round_idx (cnt_q[3:0] + 4'(k)),
         .mode      (mode_q),
         .l_nxt     (l_ch[k+1]),
         .r_nxt     (r_ch[k+1]),
         .c_nxt     (c_ch[k+1]),
         .d_nxt     (d_ch[k+1])
      );
   end

   assign last_round = (cnt_q + 5'(ROUNDS_PER_CYCLE)) == 5'd16;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_round) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_q      <= '0;
         r_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         data_out <= '0;
      end else if (state_q == ST_IDLE && in_valid) begin
         {l_q, r_q} <= ip_perm(data_in);
         {c_q, d_q} <= pc1_perm(key);
         mode_q     <= mode;
         cnt_q      <= '0;
      end else if (state_q == ST_RUN) begin
         l_q   <= l_ch[ROUNDS_PER_CYCLE];
         r_q   <= r_ch[ROUNDS_PER_CYCLE];
         c_q   <= c_ch[ROUNDS_PER_CYCLE];
         d_q   <= d_ch[ROUNDS_PER_CYCLE];
         cnt_q <= cnt_q + 5'(ROUNDS_PER_CYCLE);
         // The final swap is folded into the output: FP is applied to {R16, L16}.
         if (last_round) data_out <= fp_perm({r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]});
      end
   end

endmodule

// File: tb/tb_des_iterative_core.sv
// Directed bench: one R=1 core for protocol/vector checks plus R=2/4/8/16 cores for the latency sweep.
// Expected blocks are queued at accept and popped when a result appears.
module tb_des_iterative_core;

   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] C2 = 64'h8787878787878787;
   localparam logic [63:0] PARITY = 64'h0101010101010101;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        mode;
   logic [63:0] key;
   logic [63:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_out;
   logic        busy;

   logic        sw_in_valid;
   logic        sw_out_ready;
   logic [3:0]  sw_in_ready;
   logic [3:0]  sw_out_valid;
   logic [3:0]  sw_busy;
   logic [63:0] sw_data_out [4];

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q [$];
   logic [63:0] sw_exp_q [$];

   always #5 clk = ~clk;

   des_iterative_core #(.ROUNDS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .key(key), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .busy(busy));

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      des_iterative_core #(.ROUNDS_PER_CYCLE(2 << g)) u_sw (
         .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]), .mode(mode),
         .key(key), .data_in(data_in), .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
         .data_out(sw_data_out[g]), .busy(sw_busy[g]));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic accept(input string tag, input logic m, input logic [63:0] k,
                         input logic [63:0] d, input logic [63:0] x);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chkb({tag, "_in_ready"}, in_ready, 1'b1);
      mode = m; key = k; data_in = d; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      exp_q.push_back(x);
      chkb({tag, "_ready_drop"}, in_ready, 1'b0);
      chkb({tag, "_busy"}, busy, 1'b1);
   endtask

   // Called #1 after the accept edge; leaves out_valid pending.
   task automatic wait_out(input string tag, input int lat_exp, input bit scramble);
      int lat = 0;
      logic [63:0] x;
      do begin
         @(posedge clk);
         #1 lat++;
         if (scramble) begin
            key = {$urandom, $urandom};
            data_in = {$urandom, $urandom};
            mode = ~mode;
         end
      end while (!out_valid && lat < 100);
      chki({tag, "_latency"}, lat, lat_exp);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
         x = exp_q.pop_front();
         chk({tag, "_data"}, data_out, x);
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chkb({tag, "_ready_back"}, in_ready, 1'b1);
      chkb({tag, "_valid_drop"}, out_valid, 1'b0);
   endtask

   task automatic sweep(input string tag, input logic [63:0] k);
      int lat [4] = '{default: 0};
      int cyc = 0;
      logic [63:0] x;
      @(negedge clk);
      chki({tag, "_in_ready"}, int'(sw_in_ready), 15);
      mode = 1'b0; key = k; data_in = P1; sw_in_valid = 1'b1;
      @(posedge clk);
      #1 sw_in_valid = 1'b0;
      sw_exp_q.push_back(C1);
      chki({tag, "_busy"}, int'(sw_busy), 15);
      while (sw_out_valid != 4'hF && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
         for (int i = 0; i < 4; i++)
            if (sw_out_valid[2'(i)] && lat[i] == 0) lat[i] = cyc;
      end
      x = sw_exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
         chki($sformatf("%s_r%0d_latency", tag, 2 << i), lat[i], 8 >> i);
         chk($sformatf("%s_r%0d_data", tag, 2 << i), sw_data_out[i], x);
      end
      @(negedge clk);
      sw_out_ready = 1'b1;
      @(posedge clk);
      #1 sw_out_ready = 1'b0;
      chki({tag, "_ready_back"}, int'(sw_in_ready), 15);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] held;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
      key = '0; data_in = '0; sw_in_valid = 1'b0; sw_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chkb("rst_in_ready", in_ready, 1'b1);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chk("rst_data_out", data_out, 64'h0);

      accept("enc1", 1'b0, K1, P1, C1);
      wait_out("enc1", 16, 1'b0);
      release_out("enc1");

      accept("dec1", 1'b1, K1, C1, P1);
      wait_out("dec1", 16, 1'b0);
      release_out("dec1");

      accept("dec2", 1'b1, K2, 64'h0, C2);
      wait_out("dec2", 16, 1'b0);
      release_out("dec2");

      accept("parity", 1'b0, K1 ^ PARITY, P1, C1);
      wait_out("parity", 16, 1'b0);
      release_out("parity");

      // Backpressure: result held 20 cycles while a second request waits.
      accept("bp1", 1'b0, K1, P1, C1);
      wait_out("bp1", 16, 1'b0);
      held = data_out;
      @(negedge clk);
      mode = 1'b1; key = K1; data_in = C1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("bp_stable", data_out, held);
         chkb("bp_in_ready", in_ready, 1'b0);
         chkb("bp_out_valid", out_valid, 1'b1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chkb("bp_ready_back", in_ready, 1'b1);
      chkb("bp_valid_drop", out_valid, 1'b0);
      chk("bp_data_kept", data_out, held);
      @(posedge clk);
      #1 in_valid = 1'b0;
      exp_q.push_back(P1);
      chkb("bp2_accepted", in_ready, 1'b0);
      wait_out("bp2", 16, 1'b0);
      release_out("bp2");

      accept("iso", 1'b0, K1, P1, C1);
      wait_out("iso", 16, 1'b1);
      release_out("iso");

      // Reset after eight rounds aborts the operation.
      accept("midrst", 1'b0, K1, P1, C1);
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chkb("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_data_out", data_out, 64'h0);
      chkb("midrst_busy", busy, 1'b0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chkb("midrst_in_ready", in_ready, 1'b1);
      chkb("midrst_no_output", out_valid, 1'b0);
      accept("postrst", 1'b0, K1, P1, C1);
      wait_out("postrst", 16, 1'b0);
      release_out("postrst");

      sweep("sweep", K1);
      sweep("sweep_par", K1 ^ PARITY);

      chki("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/des_iterative_core.md
# des_iterative_core

Sequential, handshaked DES engine that succeeds the combinational DES top level in the crypto datapath. It performs one 64-bit DES encryption or decryption per transaction, iterating the 16 Feistel rounds over several clock cycles. A parameter selects how many rounds are unrolled per cycle, trading area against latency. Input and output use valid/ready handshakes so the block sits between a block-mode controller and a result FIFO.

## Interface
- ROUNDS_PER_CYCLE, default 1: Feistel rounds computed per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  a request is present on DATA_IN/KEY/MODE.
- IN_READY  out  1  block can accept a request; high only in IDLE.
- MODE  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- KEY  in  64  DES key including parity bits; sampled at accept; parity bits ignored.
- DATA_IN  in  64  plaintext (encrypt) or ciphertext (decrypt); sampled at accept.
- OUT_VALID  out  1  DATA_OUT holds a result.
- OUT_READY  in  1  downstream accepts the result.
- DATA_OUT  out  64  result block, registered.
- BUSY  out  1  high in RUN or DONE.

## Operation
- Let N = 16 / ROUNDS_PER_CYCLE.
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - IN_READY = 1.
  - Accept occurs on IN_VALID && IN_READY at a rising edge. At that edge:
    - IP(DATA_IN) loads into L/R (32 bits each).
    - PC-1(KEY) loads into C/D (28 bits each).
    - MODE is latched.
    - The round counter clears.
  - Go to RUN.
- **RUN**
  - Each edge applies ROUNDS_PER_CYCLE rounds and adds ROUNDS_PER_CYCLE to the round counter.
  - Round: L' = R, R' = L ^ f(R, K). f is E-expansion, XOR with the subkey, S-boxes, then P.
  - Encrypt key schedule: before each round n, rotate C/D left by SHIFT[n]. SHIFT for rounds 1..16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt key schedule:
    - Round 1 uses PC-2 of the unrotated C/D.
    - Round j ≥ 2 first rotates C/D right by SHIFT[18−j].
  - On the edge completing round 16:
    - DATA_OUT <= FP({R16, L16}).
    - OUT_VALID <= 1.
    - Go to DONE.
- **DONE**
  - DATA_OUT and OUT_VALID hold steady.
  - On OUT_READY at an edge: OUT_VALID <= 0 and go to IDLE. DATA_OUT keeps its last value.
- Input changes outside the accept edge have no effect on an in-flight operation.
- IN_VALID during RUN or DONE is ignored. It is not queued.
- OUT_READY held low stalls indefinitely in DONE. There is no timeout.

## Timing
- Reset values, all asserted asynchronously by RST_N low:
  - IN_READY = 1 once reset is released.
  - OUT_VALID = 0, BUSY = 0, DATA_OUT = 0.
  - L, R, C, D and the round counter = 0.
  - FSM = IDLE.
- Latency: accept at edge t0 gives OUT_VALID = 1 after edge t0+N. Examples: N = 16 for R=1, N = 4 for R=4, N = 1 for R=16.
- IN_READY falls after the accept edge.
- IN_READY returns high after the edge at which OUT_VALID && OUT_READY.
- Minimum spacing between accepts is N+2 cycles when OUT_READY is held high.
- OUT_VALID && OUT_READY is only possible in DONE, so there is no simultaneous-accept case.
- Reset mid-RUN or mid-DONE: the operation is aborted with no output produced. The first post-reset accept behaves as from cold.

## Structure
- Package des_pkg holds:
  - IP, FP, E, P, PC-1 and PC-2 permutation tables.
  - The eight S-box tables.
  - The SHIFT schedule.
  - The FSM state enum.
  - Permutation helper functions.
- Sub-module des_round: purely combinational.
  - Inputs: L, R, C, D, round index, mode.
  - Outputs: L', R', C', D'.
  - Contains the rotation, PC-2 and f.
- The core instantiates ROUNDS_PER_CYCLE des_round instances in a chain between the state registers.

## Test plan
- Encrypt, ROUNDS_PER_CYCLE=1: KEY=133457799BBCDFF1, DATA_IN=0123456789ABCDEF, MODE=0 -> DATA_OUT=85E813540F0AB405, with OUT_VALID exactly 16 cycles after accept.
- Decrypt, same key: DATA_IN=85E813540F0AB405, MODE=1 -> DATA_OUT=0123456789ABCDEF. Rerun with KEY=0E329232EA6D0D73, DATA_IN=0000000000000000, MODE=1 -> 8787878787878787.
- Parameter sweep R ∈ {2,4,8,16}: the first vector gives the same result with latency 8/4/2/1 cycles. Flipping the KEY parity bits (LSB of each byte) does not change the result.
- Backpressure:
  - Hold OUT_READY=0 for 20 cycles in DONE -> DATA_OUT stable, IN_READY=0, and a second IN_VALID is ignored.
  - Release OUT_READY -> IN_READY=1 the next cycle, then the second request completes correctly.
- Input isolation: change KEY/DATA_IN/MODE every cycle during RUN -> result still equals the vector sampled at accept.
- Reset mid-RUN: pull RST_N low at round 8 -> OUT_VALID=0, DATA_OUT=0, IN_READY=1 after release. The next encrypt gives 85E813540F0AB405.
